mem_bus_arbiter: RTL and testbench

//  Shares the single 64-bit off-chip memory port between instruction fetch (Imem) and the DMEM

---
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the off-chip memory port and mem_bus_arbiter.
// The arbiter connects through the slave modport; the environment drives through master.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic [1:0]        Imem_command;
    logic [ADDR_W-1:0] Imem_addr;
    logic [1:0]        Dmem_command;
    logic [ADDR_W-1:0] Dmem_addr;
    logic [1:0]        Dmem_size;
    logic [63:0]       Dmem_data;
    logic [3:0]        mem2proc_response;
    logic [63:0]       mem2proc_data;
    logic [3:0]        mem2proc_tag;

    logic [1:0]        proc2mem_command;
    logic [ADDR_W-1:0] proc2mem_addr;
    logic [1:0]        proc2mem_size;
    logic [63:0]       proc2mem_data;
    logic [3:0]        Imem2proc_response;
    logic [3:0]        Dmem2proc_response;
    logic [3:0]        Imem2proc_tag;
    logic [3:0]        Dmem2proc_tag;
    logic [63:0]       mem2proc_data_out;
    logic [3:0]        d_outstanding;
    logic              tag_err;

    modport slave (
        input  Imem_command, Imem_addr, Dmem_command, Dmem_addr, Dmem_size, Dmem_data,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data,
               Imem2proc_response, Dmem2proc_response, Imem2proc_tag, Dmem2proc_tag,
               mem2proc_data_out, d_outstanding, tag_err
    );

    modport master (
        output Imem_command, Imem_addr, Dmem_command, Dmem_addr, Dmem_size, Dmem_data,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data,
               Imem2proc_response, Dmem2proc_response, Imem2proc_tag, Dmem2proc_tag,
               mem2proc_data_out, d_outstanding, tag_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the off-chip memory port between fetch and data: Dmem priority with an Imem starvation
// guard, plus a per-tag owner table that steers each load completion back to its requester.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 15
) (
    input  logic             clock,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [1:0] CMD_NONE    = 2'd0;
    localparam logic [1:0] CMD_LOAD    = 2'd1;
    localparam logic [1:0] CMD_STORE   = 2'd2;
    localparam logic [1:0] SIZE_DOUBLE = 2'd3;
    localparam logic [3:0] STARVE_LIM  = 4'(STARVE_LIMIT);
    localparam logic [4:0] MAX_TAG     = 5'(NUM_TAGS);

    typedef enum logic [1:0] {GNT_NONE, GNT_IMEM, GNT_DMEM} grant_e;

    // owner bit: 0 = Imem, 1 = Dmem
    logic [NUM_TAGS:1] valid_q, valid_d;
    logic [NUM_TAGS:1] owner_q, owner_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              tag_err_q, tag_err_d;

    grant_e            grant;
    logic              starve;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [63:0]       data;
    logic [3:0]        resp;
    logic [3:0]        cpl_tag;
    logic              resp_in_range, cpl_in_range;
    logic              alloc, cpl_hit, cpl_miss;
    logic [3:0]        i_tag, d_tag;
    logic [3:0]        d_count;

    assign resp          = bus.mem2proc_response;
    assign cpl_tag       = bus.mem2proc_tag;
    assign resp_in_range = (resp != 4'd0) && ({1'b0, resp} <= MAX_TAG);
    assign cpl_in_range  = (cpl_tag != 4'd0) && ({1'b0, cpl_tag} <= MAX_TAG);

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it
    // holding its old value and no latch is inferred.
    always_comb begin
        starve = (starve_cnt_q >= STARVE_LIM) && (bus.Imem_command != CMD_NONE);
        grant  = GNT_NONE;
        if (bus.Dmem_command != CMD_NONE && !starve) begin
            grant = GNT_DMEM;
        end else if (bus.Imem_command != CMD_NONE) begin
            grant = GNT_IMEM;
        end
    end

    always_comb begin
        cmd  = CMD_NONE;
        addr = '0;
        size = '0;
        data = '0;
        unique case (grant)
            GNT_IMEM: begin
                cmd  = bus.Imem_command;
                addr = bus.Imem_addr;
                size = SIZE_DOUBLE;
            end
            GNT_DMEM: begin
                cmd  = bus.Dmem_command;
                addr = bus.Dmem_addr;
                size = bus.Dmem_size;
                if (bus.Dmem_command == CMD_STORE) data = bus.Dmem_data;
            end
            default: ;
        endcase
    end

    assign cpl_hit  = cpl_in_range && valid_q[cpl_tag];
    assign cpl_miss = (cpl_tag != 4'd0) && !cpl_hit;
    assign alloc    = (grant != GNT_NONE) && resp_in_range && (cmd == CMD_LOAD);
    assign i_tag    = (cpl_hit && !owner_q[cpl_tag]) ? cpl_tag : 4'd0;
    assign d_tag    = (cpl_hit &&  owner_q[cpl_tag]) ? cpl_tag : 4'd0;

    // Allocation is applied after the completion clear so a reused tag stays valid with its new owner.
    always_comb begin
        valid_d   = valid_q;
        owner_d   = owner_q;
        tag_err_d = tag_err_q | cpl_miss;
        if (cpl_hit) valid_d[cpl_tag] = 1'b0;
        if (alloc) begin
            valid_d[resp] = 1'b1;
            owner_d[resp] = (grant == GNT_DMEM);
        end
        starve_cnt_d = starve_cnt_q;
        if (bus.Imem_command == CMD_NONE || grant == GNT_IMEM) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        d_count = '0;
        for (int t = 1; t <= NUM_TAGS; t++) begin
            d_count = d_count + 4'(valid_q[t] & owner_q[t]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= '0;
            owner_q      <= '0;
            starve_cnt_q <= '0;
            tag_err_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            tag_err_q    <= tag_err_d;
        end
    end

    always_comb begin
        bus.proc2mem_command   = reset ? CMD_NONE : cmd;
        bus.proc2mem_addr      = reset ? '0 : addr;
        bus.proc2mem_size      = reset ? '0 : size;
        bus.proc2mem_data      = reset ? '0 : data;
        bus.Imem2proc_response = (reset || grant != GNT_IMEM) ? 4'd0 : resp;
        bus.Dmem2proc_response = (reset || grant != GNT_DMEM) ? 4'd0 : resp;
        bus.Imem2proc_tag      = reset ? 4'd0 : i_tag;
        bus.Dmem2proc_tag      = reset ? 4'd0 : d_tag;
        bus.mem2proc_data_out  = reset ? '0 : bus.mem2proc_data;
        bus.d_outstanding      = reset ? 4'd0 : d_count;
        bus.tag_err            = reset ? 1'b0 : tag_err_q;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a tag-map/denial-count model checks every output each cycle,
// and hand-computed literals pin the key scenarios.
module tb_mem_bus_arbiter;
    localparam int ADDR_W       = 16;
    localparam int STARVE_LIMIT = 4;
    localparam int NUM_TAGS     = 15;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_bus_arbiter #(
        .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT), .NUM_TAGS(NUM_TAGS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: tag -> owning side (1 = Imem, 2 = Dmem); a present key means the tag is in flight.
    int owner_of[int];
    int denials = 0;
    bit model_err = 1'b0;

    task automatic model_step();
        int         side = 0;
        int         t = int'(bus.mem2proc_tag);
        int         r = int'(bus.mem2proc_response);
        logic [1:0] e_cmd = 0, e_size = 0;
        logic [15:0] e_addr = 0;
        logic [63:0] e_data = 0;
        logic [3:0] e_iresp = 0, e_dresp = 0, e_itag = 0, e_dtag = 0;
        int         e_dout = 0;
        bit         starving;

        if (!reset) begin
            starving = (denials >= STARVE_LIMIT) && (bus.Imem_command != 0);
            if (bus.Dmem_command != 0 && !starving) side = 2;
            else if (bus.Imem_command != 0)        side = 1;

            if (side == 1) begin
                e_cmd = bus.Imem_command; e_addr = bus.Imem_addr; e_size = 2'd3;
                e_iresp = bus.mem2proc_response;
            end else if (side == 2) begin
                e_cmd = bus.Dmem_command; e_addr = bus.Dmem_addr; e_size = bus.Dmem_size;
                e_data = (bus.Dmem_command == 2) ? bus.Dmem_data : 64'd0;
                e_dresp = bus.mem2proc_response;
            end
            if (t != 0 && owner_of.exists(t)) begin
                if (owner_of[t] == 1) e_itag = 4'(t);
                else                  e_dtag = 4'(t);
            end
            foreach (owner_of[k]) if (owner_of[k] == 2) e_dout++;
        end

        check("model:proc2mem_command",   64'(bus.proc2mem_command),   64'(e_cmd));
        check("model:proc2mem_addr",      64'(bus.proc2mem_addr),      64'(e_addr));
        check("model:proc2mem_size",      64'(bus.proc2mem_size),      64'(e_size));
        check("model:proc2mem_data",      bus.proc2mem_data,           e_data);
        check("model:Imem2proc_response", 64'(bus.Imem2proc_response), 64'(e_iresp));
        check("model:Dmem2proc_response", 64'(bus.Dmem2proc_response), 64'(e_dresp));
        check("model:Imem2proc_tag",      64'(bus.Imem2proc_tag),      64'(e_itag));
        check("model:Dmem2proc_tag",      64'(bus.Dmem2proc_tag),      64'(e_dtag));
        check("model:mem2proc_data_out",  bus.mem2proc_data_out,       reset ? 64'd0 : bus.mem2proc_data);
        check("model:d_outstanding",      64'(bus.d_outstanding),      64'(e_dout));
        check("model:tag_err",            64'(bus.tag_err),            64'(reset ? 1'b0 : model_err));

        if (reset) begin
            owner_of.delete();
            denials   = 0;
            model_err = 1'b0;
        end else begin
            if (t != 0) begin
                if (owner_of.exists(t)) owner_of.delete(t);
                else                    model_err = 1'b1;
            end
            if (side != 0 && r != 0 && e_cmd == 2'd1) owner_of[r] = side;
            if (bus.Imem_command == 0 || side == 1) denials = 0;
            else if (denials < 15)                  denials++;
        end
    endtask

    always @(negedge clock) model_step();

    // One clock of stimulus: drive just after the rising edge, return at the falling edge.
    task automatic cyc(input logic rst,
                       input logic [1:0] icmd, input logic [15:0] iaddr,
                       input logic [1:0] dcmd, input logic [15:0] daddr,
                       input logic [1:0] dsize, input logic [63:0] ddata,
                       input logic [3:0] resp, input logic [3:0] ctag, input logic [63:0] cdata);
        @(posedge clock);
        #1;
        reset                 = rst;
        bus.Imem_command      = icmd;
        bus.Imem_addr         = iaddr;
        bus.Dmem_command      = dcmd;
        bus.Dmem_addr         = daddr;
        bus.Dmem_size         = dsize;
        bus.Dmem_data         = ddata;
        bus.mem2proc_response = resp;
        bus.mem2proc_tag      = ctag;
        bus.mem2proc_data     = cdata;
        @(negedge clock);
    endtask

    task automatic idle();
        cyc(1'b0, 2'd0, 16'h0, 2'd0, 16'h0, 2'd0, 64'h0, 4'd0, 4'd0, 64'h0);
    endtask

    initial begin
        reset                 = 1'b1;
        bus.Imem_command      = '0;
        bus.Imem_addr         = '0;
        bus.Dmem_command      = '0;
        bus.Dmem_addr         = '0;
        bus.Dmem_size         = '0;
        bus.Dmem_data         = '0;
        bus.mem2proc_response = '0;
        bus.mem2proc_tag      = '0;
        bus.mem2proc_data     = '0;

        // Outputs are held at zero while reset is high, even with a live request.
        cyc(1'b1, 2'd0, 16'h0, 2'd1, 16'h0AAA, 2'd2, 64'h0, 4'd4, 4'd1, 64'h55);
        check("reset:proc2mem_command", 64'(bus.proc2mem_command), 64'd0);
        check("reset:Dmem2proc_response", 64'(bus.Dmem2proc_response), 64'd0);
        cyc(1'b1, 2'd0, 16'h0, 2'd0, 16'h0, 2'd0, 64'h0, 4'd0, 4'd0, 64'h0);

        // No requests: quiet bus.
        for (int i = 0; i < 10; i++) begin
            idle();
            check("idle:proc2mem_command", 64'(bus.proc2mem_command), 64'd0);
            check("idle:responses", 64'({bus.Imem2proc_response, bus.Dmem2proc_response}), 64'd0);
        end

        // Imem load alone, then its completion.
        cyc(1'b0, 2'd1, 16'h0100, 2'd0, 16'h0, 2'd0, 64'h0, 4'd3, 4'd0, 64'h0);
        check("imem:proc2mem_addr", 64'(bus.proc2mem_addr), 64'h0100);
        check("imem:proc2mem_size", 64'(bus.proc2mem_size), 64'd3);
        check("imem:Imem2proc_response", 64'(bus.Imem2proc_response), 64'd3);
        check("imem:Dmem2proc_response", 64'(bus.Dmem2proc_response), 64'd0);
        idle();
        check("imem:d_outstanding", 64'(bus.d_outstanding), 64'd0);
        cyc(1'b0, 2'd0, 16'h0, 2'd0, 16'h0, 2'd0, 64'h0, 4'd0, 4'd3, 64'h1122334455667788);
        check("imem:Imem2proc_tag", 64'(bus.Imem2proc_tag), 64'd3);
        check("imem:Dmem2proc_tag", 64'(bus.Dmem2proc_tag), 64'd0);
        check("imem:mem2proc_data_out", bus.mem2proc_data_out, 64'h1122334455667788);
        idle();
        check("imem:tag_err", 64'(bus.tag_err), 64'd0);

        // Both request, all rejected: Dmem four times, Imem forced on the fifth, then Dmem again.
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b0, 2'd1, 16'h0200, 2'd1, 16'h0300, 2'd2, 64'h0, 4'd0, 4'd0, 64'h0);
            check($sformatf("starve:addr_cycle%0d", k), 64'(bus.proc2mem_addr),
                  (k == 5) ? 64'h0200 : 64'h0300);
        end

        // Dmem store: data passes, store not tracked, so its completion is an error.
        cyc(1'b0, 2'd0, 16'h0, 2'd2, 16'h0040, 2'd3, 64'hDEADBEEF_CAFEF00D, 4'd5, 4'd0, 64'h0);
        check("store:proc2mem_command", 64'(bus.proc2mem_command), 64'd2);
        check("store:proc2mem_data", bus.proc2mem_data, 64'hDEADBEEF_CAFEF00D);
        check("store:Dmem2proc_response", 64'(bus.Dmem2proc_response), 64'd5);
        idle();
        check("store:d_outstanding", 64'(bus.d_outstanding), 64'd0);
        cyc(1'b0, 2'd0, 16'h0, 2'd0, 16'h0, 2'd0, 64'h0, 4'd0, 4'd5, 64'h0);
        check("store:tags", 64'({bus.Imem2proc_tag, bus.Dmem2proc_tag}), 64'd0);
        idle();
        check("store:tag_err", 64'(bus.tag_err), 64'd1);

        // Tag reuse: completion of 7 goes to Dmem while Imem takes 7 in the same cycle.
        cyc(1'b0, 2'd0, 16'h0, 2'd1, 16'h0080, 2'd2, 64'h0, 4'd7, 4'd0, 64'h0);
        check("reuse:Dmem2proc_response", 64'(bus.Dmem2proc_response), 64'd7);
        cyc(1'b0, 2'd1, 16'h0110, 2'd0, 16'h0, 2'd0, 64'h0, 4'd7, 4'd7, 64'h77);
        check("reuse:d_outstanding", 64'(bus.d_outstanding), 64'd1);
        check("reuse:Dmem2proc_tag", 64'(bus.Dmem2proc_tag), 64'd7);
        check("reuse:Imem2proc_tag", 64'(bus.Imem2proc_tag), 64'd0);
        check("reuse:Imem2proc_response", 64'(bus.Imem2proc_response), 64'd7);
        idle();
        check("reuse:d_outstanding_after", 64'(bus.d_outstanding), 64'd0);
        cyc(1'b0, 2'd0, 16'h0, 2'd0, 16'h0, 2'd0, 64'h0, 4'd0, 4'd7, 64'h78);
        check("reuse:Imem2proc_tag_2nd", 64'(bus.Imem2proc_tag), 64'd7);
        check("reuse:Dmem2proc_tag_2nd", 64'(bus.Dmem2proc_tag), 64'd0);

        // Three Dmem loads, then reset drops them; a completion during reset is ignored.
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, 2'd0, 16'h0, 2'd1, 16'(16'h0400 + k), 2'd3, 64'h0, 4'(k), 4'd0, 64'h0);
        end
        idle();
        check("drop:d_outstanding", 64'(bus.d_outstanding), 64'd3);
        cyc(1'b1, 2'd0, 16'h0, 2'd0, 16'h0, 2'd0, 64'h0, 4'd0, 4'd1, 64'h0);
        check("drop:Dmem2proc_tag_in_reset", 64'(bus.Dmem2proc_tag), 64'd0);
        idle();
        check("drop:d_outstanding_after", 64'(bus.d_outstanding), 64'd0);
        check("drop:tag_err_cleared", 64'(bus.tag_err), 64'd0);
        cyc(1'b0, 2'd0, 16'h0, 2'd0, 16'h0, 2'd0, 64'h0, 4'd0, 4'd2, 64'h0);
        check("drop:tags", 64'({bus.Imem2proc_tag, bus.Dmem2proc_tag}), 64'd0);
        idle();
        check("drop:tag_err", 64'(bus.tag_err), 64'd1);

        idle();
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
